// File: rtl/div_result_queue_if.sv
// Handshake bundle for div_result_queue: operand intake and result drain.
// The slave modport is the stage itself; master is whoever feeds and drains it.
interface div_result_queue_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a_in;
    logic [3:0] b_in;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_q;
    logic       out_err;

    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, out_q, out_err
    );

    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, out_q, out_err
    );
endinterface

// File: rtl/div_result_queue.sv
// Registered operand stage in front of the 4-bit combinational divider, plus a
// small result FIFO and a saturating divide-by-zero counter.
module div_result_queue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned ERR_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    div_result_queue_if.slave  bus,
    output logic [3:0]         div_a,
    output logic [3:0]         div_b,
    input  logic [3:0]         div_s,
    input  logic               div_err,
    output logic [ERR_W-1:0]   err_count,
    input  logic               err_clr
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_V = (CW + 1)'(DEPTH);

    logic          op_valid;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [3:0]    mem_q   [DEPTH];
    logic          mem_err [DEPTH];

    logic          accept;
    logic          push;
    logic          pop;
    logic [3:0]    push_q;
    logic [CW:0]   used;

    // Credits count the in-flight operand too, so a capture push never finds the FIFO full.
    assign used         = {1'b0, count} + {{CW{1'b0}}, op_valid};
    assign bus.in_ready = (used < DEPTH_V);

    assign accept = bus.in_valid && bus.in_ready;
    assign push   = op_valid;
    assign pop    = bus.out_valid && bus.out_ready;
    assign push_q = div_err ? 4'h0 : div_s;

    assign bus.out_valid = (count != '0);
    assign bus.out_q     = mem_q[rd_ptr];
    assign bus.out_err   = mem_err[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_valid <= 1'b0;
            div_a    <= '0;
            div_b    <= '0;
        end else begin
            op_valid <= accept;
            if (accept) begin
                div_a <= bus.a_in;
                div_b <= bus.b_in;
            end
        end
    end

    // Storage is cleared on reset so the head reads as zero before the first push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q   <= '{default: '0};
            mem_err <= '{default: 1'b0};
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr]   <= push_q;
                mem_err[wr_ptr] <= div_err;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || err_clr) begin
            err_count <= '0;
        end else if (push && div_err && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_div_result_queue.sv
// Directed bench for div_result_queue: queue-based reference model checked every
// cycle, plus hand-computed expectations for the key scenarios.
module tb_div_result_queue;
    localparam int DEPTH = 2;
    localparam int ERR_W = 4;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             err_clr;
    logic [3:0]       div_a;
    logic [3:0]       div_b;
    logic [3:0]       div_s;
    logic             div_err;
    logic [ERR_W-1:0] err_count;

    div_result_queue_if bus ();

    div_result_queue #(.DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_s     (div_s),
        .div_err   (div_err),
        .err_count (err_count),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    // Divider stand-in; on B==0 it drives a junk quotient that the stage must mask.
    always_comb begin
        div_err = (div_b == 4'd0);
        if (div_b == 4'd0) div_s = 4'hF;
        else               div_s = div_a / div_b;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [3:0] q;
        logic       err;
    } res_t;

    function automatic res_t divide(input logic [3:0] a, input logic [3:0] b);
        res_t r;
        if (b == 4'd0) begin
            r.q = 4'd0; r.err = 1'b1;
        end else begin
            r.q = a / b; r.err = 1'b0;
        end
        return r;
    endfunction

    // Reference model: list of queued results, one pending operand, last accepted pair.
    res_t       mq[$];
    bit         m_pend;
    logic [3:0] m_pa, m_pb;
    logic [3:0] m_da, m_db;
    int         m_ec;
    bit         m_live = 1'b0;

    always @(posedge clk) begin
        bit   rdy;
        bit   acc;
        res_t r;
        if (!rst_n) begin
            mq.delete();
            m_pend = 1'b0;
            m_da   = 4'd0;
            m_db   = 4'd0;
            m_ec   = 0;
            m_live = 1'b1;
        end else if (m_live) begin
            rdy = (mq.size() + int'(m_pend)) < DEPTH;
            acc = bus.in_valid && rdy;
            if (mq.size() > 0 && bus.out_ready) void'(mq.pop_front());
            r.err = 1'b0;
            if (m_pend) begin
                r = divide(m_pa, m_pb);
                mq.push_back(r);
            end
            if (err_clr) m_ec = 0;
            else if (m_pend && r.err && m_ec < ERR_MAX) m_ec++;
            m_pend = acc;
            if (acc) begin
                m_pa = bus.a_in; m_pb = bus.b_in;
                m_da = bus.a_in; m_db = bus.b_in;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (m_live) begin
            chk("in_ready", 32'(bus.in_ready), 32'((mq.size() + int'(m_pend)) < DEPTH));
            chk("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
            if (mq.size() > 0) begin
                chk("out_q", 32'(bus.out_q), 32'(mq[0].q));
                chk("out_err", 32'(bus.out_err), 32'(mq[0].err));
            end
            chk("div_a", 32'(div_a), 32'(m_da));
            chk("div_b", 32'(div_b), 32'(m_db));
            chk("err_count", 32'(err_count), 32'(m_ec));
        end
    end

    task automatic send(input logic [3:0] a, input logic [3:0] b);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.a_in     = a;
        bus.b_in     = b;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = bus.in_ready;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("send_accepted", 32'(ok), 32'd1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_out_q"}, 32'(bus.out_q), 32'd0);
        chk({tag, "_out_err"}, 32'(bus.out_err), 32'd0);
        chk({tag, "_err_count"}, 32'(err_count), 32'd0);
        chk({tag, "_div_a"}, 32'(div_a), 32'd0);
        chk({tag, "_div_b"}, 32'(div_b), 32'd0);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [3:0] got[$];
        bit         acc;

        rst_n         = 1'b0;
        err_clr       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a_in      = 4'd0;
        bus.b_in      = 4'd0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_state("rst");

        // 13/3: two-edge latency, then popped
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        send(4'd13, 4'd3);
        chk("s1_not_yet_valid", 32'(bus.out_valid), 32'd0);
        chk("s1_div_a", 32'(div_a), 32'd13);
        @(negedge clk);
        chk("s1_out_valid", 32'(bus.out_valid), 32'd1);
        chk("s1_out_q", 32'(bus.out_q), 32'd4);
        chk("s1_out_err", 32'(bus.out_err), 32'd0);
        @(negedge clk);
        chk("s1_empty_after_pop", 32'(bus.out_valid), 32'd0);

        // divide by zero, then clear colliding with another error push
        send(4'd7, 4'd0);
        @(negedge clk);
        chk("s2_out_q", 32'(bus.out_q), 32'd0);
        chk("s2_out_err", 32'(bus.out_err), 32'd1);
        chk("s2_err_count", 32'(err_count), 32'd1);
        send(4'd5, 4'd0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("s2_clr_wins", 32'(err_count), 32'd0);
        chk("s2_second_err", 32'(bus.out_err), 32'd1);
        @(negedge clk);

        // backpressure: third operand waits until a pop frees a credit
        bus.out_ready = 1'b0;
        send(4'd9, 4'd1);
        send(4'd8, 4'd2);
        bus.in_valid = 1'b1;
        bus.a_in     = 4'd6;
        bus.b_in     = 4'd3;
        repeat (2) @(negedge clk);
        chk("s3_stalled", 32'(bus.in_ready), 32'd0);
        chk("s3_head", 32'(bus.out_q), 32'd9);
        bus.out_ready = 1'b1;
        got.delete();
        for (int i = 0; i < 8; i++) begin
            if (i == 0) chk("s3_rdy_at_pop", 32'(bus.in_ready), 32'd0);
            if (i == 1) chk("s3_rdy_after_pop", 32'(bus.in_ready), 32'd1);
            if (bus.out_valid) got.push_back(bus.out_q);
            acc = bus.in_valid && bus.in_ready;
            @(negedge clk);
            if (acc) bus.in_valid = 1'b0;
        end
        chk("s3_count", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            chk("s3_q0", 32'(got[0]), 32'd9);
            chk("s3_q1", 32'(got[1]), 32'd4);
            chk("s3_q2", 32'(got[2]), 32'd2);
        end
        chk("s3_no_stall_left", 32'(bus.in_valid), 32'd0);

        // back-to-back ops give a simultaneous push and pop
        send(4'd15, 4'd5);
        send(4'd14, 4'd7);
        got.delete();
        for (int i = 0; i < 5; i++) begin
            if (bus.out_valid) got.push_back(bus.out_q);
            @(negedge clk);
        end
        chk("s4_count", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            chk("s4_q0", 32'(got[0]), 32'd3);
            chk("s4_q1", 32'(got[1]), 32'd2);
        end

        // saturation of the error counter
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("s5_cleared", 32'(err_count), 32'd0);
        for (int i = 0; i < 16; i++) send(4'(i), 4'd0);
        repeat (3) @(negedge clk);
        chk("s5_saturated", 32'(err_count), 32'd15);

        // reset with an operand in flight and a result queued
        bus.out_ready = 1'b0;
        send(4'd9, 4'd1);
        send(4'd8, 4'd2);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_state("s6");
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("s6_no_stale", 32'(bus.out_valid), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
